fir_tap_sequencer: RTL and testbench



---
 rtl/fir_tap_sequencer.sv | 179 +++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
`timescale 1ns/1ps
// fir_tap_sequencer: front end of the 10-tap FIR accumulator.
// Accepts a 3-bit signed sample on each accepted strobe and shifts it into
// a 10-stage delay line. It then walks the MAC through taps 1..10 and
// captures the accumulated sum as the filter output.
// Optional feature macro: FIR_OVERRUN_FLAG_EN adds the sticky oOverrun flag,
// which reports strobes that arrive while a run is in progress.
module fir_tap_sequencer (
  input  logic        iClk_12M,
  input  logic        iRsn,
  input  logic        iEnSample,
  input  logic [2:0]  iFirIn,
  input  logic [15:0] iMac,
  output logic [2:0]  oDelay1,
  output logic [2:0]  oDelay2,
  output logic [2:0]  oDelay3,
  output logic [2:0]  oDelay4,
  output logic [2:0]  oDelay5,
  output logic [2:0]  oDelay6,
  output logic [2:0]  oDelay7,
  output logic [2:0]  oDelay8,
  output logic [2:0]  oDelay9,
  output logic [2:0]  oDelay10,
  output logic [3:0]  oEnMul,
  output logic        oEnAdd,
  output logic        oEnAcc,
  output logic [3:0]  oCoeffAddr,
  output logic        oBusy,
  output logic [15:0] oFirOut,
`ifdef FIR_OVERRUN_FLAG_EN
  output logic        oOverrun,
`endif
  output logic        oFirOutValid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [3:0] LAST_TAP = 4'd10;

  state_t      state_q, state_d;
  logic [2:0]  delay_q [10];
  logic [2:0]  delay_d [10];
  logic [3:0]  tap_q, tap_d;
  logic [3:0]  en_mul_q, en_mul_d;
  logic [3:0]  coeff_addr_q, coeff_addr_d;
  logic        en_add_q, en_add_d;
  logic        en_acc_q, en_acc_d;
  logic        busy_q, busy_d;
  logic [15:0] fir_out_q, fir_out_d;
  logic        fir_out_valid_q, fir_out_valid_d;

  // Next state, delay-line shift and the registered control outputs for the next cycle
  always_comb begin
    state_d         = state_q;
    tap_d           = tap_q;
    for (int i = 0; i < 10; i++) begin
      delay_d[i] = delay_q[i];
    end
    en_mul_d        = 4'd0;
    coeff_addr_d    = 4'd0;
    en_add_d        = 1'b0;
    en_acc_d        = 1'b0;
    busy_d          = 1'b0;
    fir_out_d       = fir_out_q;
    fir_out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iEnSample) begin
          delay_d[0] = iFirIn;
          for (int i = 1; i < 10; i++) begin
            delay_d[i] = delay_q[i-1];
          end
          tap_d        = 4'd1;
          en_mul_d     = 4'd1;
          coeff_addr_d = 4'd0;
          en_add_d     = 1'b1;
          en_acc_d     = 1'b1;
          busy_d       = 1'b1;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (tap_q == LAST_TAP) begin
          state_d = ST_DONE;
        end else begin
          tap_d        = tap_q + 4'd1;
          en_mul_d     = tap_q + 4'd1;
          coeff_addr_d = tap_q;
          en_add_d     = 1'b1;
          en_acc_d     = 1'b1;
        end
      end
      ST_DONE: begin
        fir_out_d       = iMac;
        fir_out_valid_d = 1'b1;
        state_d         = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, delay line and output registers; reset aborts any run immediately
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q         <= ST_IDLE;
      tap_q           <= 4'd0;
      for (int i = 0; i < 10; i++) begin
        delay_q[i] <= 3'd0;
      end
      en_mul_q        <= 4'd0;
      coeff_addr_q    <= 4'd0;
      en_add_q        <= 1'b0;
      en_acc_q        <= 1'b0;
      busy_q          <= 1'b0;
      fir_out_q       <= 16'd0;
      fir_out_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tap_q           <= tap_d;
      for (int i = 0; i < 10; i++) begin
        delay_q[i] <= delay_d[i];
      end
      en_mul_q        <= en_mul_d;
      coeff_addr_q    <= coeff_addr_d;
      en_add_q        <= en_add_d;
      en_acc_q        <= en_acc_d;
      busy_q          <= busy_d;
      fir_out_q       <= fir_out_d;
      fir_out_valid_q <= fir_out_valid_d;
    end
  end

`ifdef FIR_OVERRUN_FLAG_EN
  logic overrun_q, overrun_d;

  // Sticky flag: any strobe seen outside IDLE is a dropped sample
  always_comb begin
    overrun_d = overrun_q | (iEnSample && (state_q != ST_IDLE));
  end

  // Overrun register, cleared only by reset
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign oOverrun = overrun_q;
`endif

  assign oDelay1      = delay_q[0];
  assign oDelay2      = delay_q[1];
  assign oDelay3      = delay_q[2];
  assign oDelay4      = delay_q[3];
  assign oDelay5      = delay_q[4];
  assign oDelay6      = delay_q[5];
  assign oDelay7      = delay_q[6];
  assign oDelay8      = delay_q[7];
  assign oDelay9      = delay_q[8];
  assign oDelay10     = delay_q[9];
  assign oEnMul       = en_mul_q;
  assign oCoeffAddr   = coeff_addr_q;
  assign oEnAdd       = en_add_q;
  assign oEnAcc       = en_acc_q;
  assign oBusy        = busy_q;
  assign oFirOut      = fir_out_q;
  assign oFirOutValid = fir_out_valid_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
`timescale 1ns/1ps
// tb_fir_tap_sequencer: self-checking bench for fir_tap_sequencer.
// The bench models the accumulator and the coefficient store around the DUT.
// Each filter output is compared with a reference convolution over a history
// of accepted samples.
module tb_fir_tap_sequencer;

  logic        iClk_12M = 1'b0;
  logic        iRsn;
  logic        iEnSample;
  logic [2:0]  iFirIn;
  logic [15:0] iMac;
  logic [2:0]  oDelay1, oDelay2, oDelay3, oDelay4, oDelay5;
  logic [2:0]  oDelay6, oDelay7, oDelay8, oDelay9, oDelay10;
  logic [3:0]  oEnMul;
  logic        oEnAdd;
  logic        oEnAcc;
  logic [3:0]  oCoeffAddr;
  logic        oBusy;
  logic [15:0] oFirOut;
  logic        oFirOutValid;
`ifdef FIR_OVERRUN_FLAG_EN
  logic        oOverrun;
  logic        ovExp;
`endif

  int checks = 0;
  int errors = 0;

  logic signed [15:0] coeff [10];
  logic signed [2:0]  hist [10];
  logic signed [2:0]  dly [10];
  logic signed [15:0] macReg;
  logic signed [15:0] prod;
  logic [15:0]        lastOut;

  typedef struct {
    int   enMul;
    int   addr;
    logic enAdd;
    logic enAcc;
    logic busy;
    logic valid;
  } ctrl_t;

  typedef struct {
    logic [2:0]  sample;
    int          dropAt;
    int          coeffSet;
    logic [15:0] expOut;
  } vec_t;

  ctrl_t ctrlTbl [13];
  vec_t  vecTbl [21];

  fir_tap_sequencer dut (
    .iClk_12M     (iClk_12M),
    .iRsn         (iRsn),
    .iEnSample    (iEnSample),
    .iFirIn       (iFirIn),
    .iMac         (iMac),
    .oDelay1      (oDelay1),
    .oDelay2      (oDelay2),
    .oDelay3      (oDelay3),
    .oDelay4      (oDelay4),
    .oDelay5      (oDelay5),
    .oDelay6      (oDelay6),
    .oDelay7      (oDelay7),
    .oDelay8      (oDelay8),
    .oDelay9      (oDelay9),
    .oDelay10     (oDelay10),
    .oEnMul       (oEnMul),
    .oEnAdd       (oEnAdd),
    .oEnAcc       (oEnAcc),
    .oCoeffAddr   (oCoeffAddr),
    .oBusy        (oBusy),
    .oFirOut      (oFirOut),
`ifdef FIR_OVERRUN_FLAG_EN
    .oOverrun     (oOverrun),
`endif
    .oFirOutValid (oFirOutValid)
  );

  // Free-running system clock
  always #5 iClk_12M = ~iClk_12M;

  // Gather the delay-line taps so the accumulator model can index them
  always_comb begin
    dly[0] = oDelay1;
    dly[1] = oDelay2;
    dly[2] = oDelay3;
    dly[3] = oDelay4;
    dly[4] = oDelay5;
    dly[5] = oDelay6;
    dly[6] = oDelay7;
    dly[7] = oDelay8;
    dly[8] = oDelay9;
    dly[9] = oDelay10;
  end

  // Product the MAC sees: the coefficient store reads combinationally, and the tap is picked by oEnMul
  always_comb begin
    int mi;
    int ci;
    int p;
    mi = int'(oEnMul) - 1;
    ci = int'(oCoeffAddr);
    p  = 0;
    if (mi >= 0 && mi < 10 && ci < 10) begin
      p = int'(coeff[ci]) * int'(dly[mi]);
    end
    prod = p[15:0];
  end

  // Accumulator model: tap 1 restarts from zero, the enables gate the add and the register
  always @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      macReg <= '0;
    end else if (oEnAcc) begin
      macReg <= ((oEnMul == 4'd1) ? 16'sd0 : macReg) + (oEnAdd ? prod : 16'sd0);
    end
  end

  assign iMac = macReg;

  // Reference filter: a plain convolution of the coefficients with the accepted-sample history
  function automatic logic [15:0] refOut();
    int s;
    s = 0;
    for (int k = 0; k < 10; k++) begin
      s += int'(coeff[k]) * int'(hist[k]);
    end
    return s[15:0];
  endfunction

  task automatic pushHist(input logic [2:0] x);
    for (int k = 9; k > 0; k--) begin
      hist[k] = hist[k-1];
    end
    hist[0] = x;
  endtask

  task automatic clearHist();
    for (int k = 0; k < 10; k++) begin
      hist[k] = '0;
    end
  endtask

  task automatic loadCoeffs(input int set);
    for (int k = 0; k < 10; k++) begin
      case (set)
        0:       coeff[k] = 16'(k + 1);
        1:       coeff[k] = 16'h7FFF;
        default: coeff[k] = 16'($urandom);
      endcase
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] allOuts();
    logic [63:0] v;
    v = 64'({oDelay10, oDelay9, oDelay8, oDelay7, oDelay6, oDelay5, oDelay4,
              oDelay3, oDelay2, oDelay1, oEnMul, oEnAdd, oEnAcc, oCoeffAddr,
              oBusy, oFirOut, oFirOutValid});
`ifdef FIR_OVERRUN_FLAG_EN
    v[63] = oOverrun;
`endif
    return v;
  endfunction

  // One accepted sample, called at a falling edge. An optional extra strobe is sent in cycle dropAt.
  // Each of the 12 cycles is checked against the control table, and the result against the model.
  task automatic applyStimulus(input logic [2:0] x, input int dropAt, input logic [2:0] dropVal,
                               output logic [15:0] outVal);
    logic [29:0] expDly;
    logic [29:0] actDly;
    iFirIn    = x;
    iEnSample = 1'b1;
    pushHist(x);
    outVal    = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge iClk_12M);
      iEnSample = (c == dropAt);
      iFirIn    = dropVal;
      checkOutput($sformatf("enMul@c%0d", c), 64'(oEnMul), 64'(ctrlTbl[c].enMul));
      checkOutput($sformatf("coeffAddr@c%0d", c), 64'(oCoeffAddr), 64'(ctrlTbl[c].addr));
      checkOutput($sformatf("enAdd@c%0d", c), 64'(oEnAdd), 64'(ctrlTbl[c].enAdd));
      checkOutput($sformatf("enAcc@c%0d", c), 64'(oEnAcc), 64'(ctrlTbl[c].enAcc));
      checkOutput($sformatf("busy@c%0d", c), 64'(oBusy), 64'(ctrlTbl[c].busy));
      checkOutput($sformatf("valid@c%0d", c), 64'(oFirOutValid), 64'(ctrlTbl[c].valid));
`ifdef FIR_OVERRUN_FLAG_EN
      if (dropAt >= 1 && dropAt <= 11 && c > dropAt) begin
        ovExp = 1'b1;
      end
      checkOutput($sformatf("overrun@c%0d", c), 64'(oOverrun), 64'(ovExp));
`endif
      if (c == 6) begin
        checkOutput("firOutHeld", 64'(oFirOut), 64'(lastOut));
      end
      if (c == 12) begin
        for (int k = 0; k < 10; k++) begin
          expDly[k*3 +: 3] = hist[k];
        end
        actDly = {oDelay10, oDelay9, oDelay8, oDelay7, oDelay6,
                  oDelay5, oDelay4, oDelay3, oDelay2, oDelay1};
        checkOutput("delayLine", 64'(actDly), 64'(expDly));
        checkOutput("firOut", 64'(oFirOut), 64'(refOut()));
        outVal  = oFirOut;
        lastOut = refOut();
      end
    end
    iEnSample = 1'b0;
  endtask

  // Safety net so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    logic [15:0] outVal;
    int          nRand;

    for (int c = 0; c <= 12; c++) begin
      ctrlTbl[c].enMul = (c >= 1 && c <= 10) ? c : 0;
      ctrlTbl[c].addr  = (c >= 1 && c <= 10) ? c - 1 : 0;
      ctrlTbl[c].enAdd = (c >= 1 && c <= 10);
      ctrlTbl[c].enAcc = (c >= 1 && c <= 10);
      ctrlTbl[c].busy  = (c >= 1 && c <= 11);
      ctrlTbl[c].valid = (c == 12);
    end

    vecTbl[0] = '{sample: 3'd1, dropAt: 0, coeffSet: 0, expOut: 16'd1};
    for (int i = 1; i <= 9; i++) begin
      vecTbl[i] = '{sample: 3'd0, dropAt: 0, coeffSet: 0, expOut: 16'(i + 1)};
    end
    vecTbl[10] = '{sample: 3'd0, dropAt: 0, coeffSet: 0, expOut: 16'd0};
    for (int i = 11; i <= 20; i++) begin
      vecTbl[i] = '{sample: 3'b100, dropAt: 0, coeffSet: 1, expOut: 16'(4 * (i - 10))};
    end
    vecTbl[13].dropAt = 6;
    vecTbl[20].dropAt = 11;

    iRsn      = 1'b0;
    iEnSample = 1'b0;
    iFirIn    = '0;
    lastOut   = '0;
`ifdef FIR_OVERRUN_FLAG_EN
    ovExp     = 1'b0;
`endif
    clearHist();
    loadCoeffs(0);

    repeat (3) @(negedge iClk_12M);
    checkOutput("resetOutputs", allOuts(), 64'd0);
    iRsn = 1'b1;
    @(negedge iClk_12M);

    $display("[TB] mid-run reset");
    iFirIn    = 3'd3;
    iEnSample = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge iClk_12M);
      iEnSample = 1'b0;
    end
    checkOutput("busyBeforeReset", 64'(oBusy), 64'd1);
    iRsn = 1'b0;
    #1;
    checkOutput("asyncResetOutputs", allOuts(), 64'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge iClk_12M);
      checkOutput("noValidInReset", 64'(oFirOutValid), 64'd0);
    end
    iRsn = 1'b1;
    clearHist();
`ifdef FIR_OVERRUN_FLAG_EN
    ovExp = 1'b0;
`endif
    for (int c = 0; c < 14; c++) begin
      @(negedge iClk_12M);
      checkOutput("idleAfterReset", allOuts(), 64'd0);
    end

    $display("[TB] table vectors: impulse, wrap, dropped strobes, back-to-back");
    for (int i = 0; i < 21; i++) begin
      if (i == 0 || vecTbl[i].coeffSet != vecTbl[i-1].coeffSet) begin
        loadCoeffs(vecTbl[i].coeffSet);
      end
      applyStimulus(vecTbl[i].sample, vecTbl[i].dropAt, 3'($urandom), outVal);
      checkOutput($sformatf("tblOut[%0d]", i), 64'(outVal), 64'(vecTbl[i].expOut));
    end

    $display("[TB] randomized samples");
    loadCoeffs(2);
    nRand = 30;
    for (int n = 0; n < nRand; n++) begin
      int gap;
      int dropAt;
      gap    = $urandom_range(0, 2);
      dropAt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 11) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge iClk_12M);
        checkOutput("idleGapBusy", 64'(oBusy), 64'd0);
      end
      applyStimulus(3'($urandom), dropAt, 3'($urandom), outVal);
    end

    @(negedge iClk_12M);
    checkOutput("finalValidLow", 64'(oFirOutValid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
